// File: rtl/arb_pkg.sv
// Shared arbitration-path definitions: grant FSM states and the default code
// width / grant timeout used by both the priority encoder and the grant decoder.
package arb_pkg;

    localparam int unsigned GD_N_SEL   = 2;
    localparam int unsigned GD_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } gd_state_t;

    // Timeout counter width: enough to hold TIMEOUT, never narrower than one bit.
    function automatic int unsigned gd_cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational N_SEL-to-2**N_SEL one-hot decoder, used for the grant vector
// and for selecting the granted unit's completion bit.
module onehot_dec #(
    parameter int unsigned N_SEL = 2
) (
    input  logic [N_SEL-1:0]      code_i,
    output logic [2**N_SEL-1:0]   onehot_o
);

    always_comb begin
        // NOTE: assign a default before the indexed write so every bit is driven on every path and no latch is inferred.
        onehot_o         = '0;
        onehot_o[code_i] = 1'b1;
    end

endmodule

// File: rtl/grant_decoder.sv
// Sequential 2-to-4 grant decoder: latches an accepted code, holds a registered
// one-hot grant until the unit completes or the timeout expires, then releases.
module grant_decoder
    import arb_pkg::*;
#(
    parameter int unsigned N_SEL   = GD_N_SEL,
    parameter int unsigned TIMEOUT = GD_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_SEL-1:0]      in_code,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [2**N_SEL-1:0]   gnt,
    output logic                  gnt_valid,
    input  logic [2**N_SEL-1:0]   done,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam int unsigned N_GNT = 2**N_SEL;
    localparam int unsigned CNT_W = gd_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    gd_state_t          state_q;
    logic [N_SEL-1:0]   code_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_GNT-1:0]   gnt_q;
    logic               timeout_err_q;

    logic [N_GNT-1:0]   in_onehot;
    logic [N_GNT-1:0]   code_onehot;
    logic               done_hit;
    logic               expired;

    onehot_dec #(.N_SEL(N_SEL)) u_in_dec (
        .code_i   (in_code),
        .onehot_o (in_onehot)
    );

    onehot_dec #(.N_SEL(N_SEL)) u_done_dec (
        .code_i   (code_q),
        .onehot_o (code_onehot)
    );

    // Only the granted unit's completion counts; other done bits are masked off.
    assign done_hit = |(done & code_onehot);
    assign expired  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            code_q        <= '0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            timeout_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q <= ST_GRANT;
                        code_q  <= in_code;
                        cnt_q   <= '0;
                        gnt_q   <= in_onehot;
                    end
                end
                ST_GRANT: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Completion takes priority over a timeout expiring on the same edge.
                    if (done_hit) begin
                        state_q <= ST_RELEASE;
                        gnt_q   <= '0;
                    end else if (expired) begin
                        state_q       <= ST_RELEASE;
                        gnt_q         <= '0;
                        timeout_err_q <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign gnt         = gnt_q;
    assign gnt_valid   = |gnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_grant_decoder.sv
// Bench for grant_decoder: one instance with the default timeout, one with
// TIMEOUT=4, both compared every cycle against a transaction-level model.
module tb_grant_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] in_code = '0;
    logic       in_valid = 1'b0;
    logic [3:0] done = '0;

    logic       rdy_a, gv_a, te_a, busy_a;
    logic [3:0] gnt_a;
    logic       rdy_b, gv_b, te_b, busy_b;
    logic [3:0] gnt_b;

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 = default timeout (15), 1 = TIMEOUT 4.
    int m_tout [2] = '{15, 4};
    bit m_on   [2];
    bit m_rel  [2];
    bit m_terr [2];
    int m_code [2];
    int m_age  [2];

    int n;

    grant_decoder u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_code     (in_code),
        .in_valid    (in_valid),
        .in_ready    (rdy_a),
        .gnt         (gnt_a),
        .gnt_valid   (gv_a),
        .done        (done),
        .timeout_err (te_a),
        .busy        (busy_a)
    );

    grant_decoder #(.N_SEL(2), .TIMEOUT(4)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_code     (in_code),
        .in_valid    (in_valid),
        .in_ready    (rdy_b),
        .gnt         (gnt_b),
        .gnt_valid   (gv_b),
        .done        (done),
        .timeout_err (te_b),
        .busy        (busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_on[i]   = 1'b0;
        m_rel[i]  = 1'b0;
        m_terr[i] = 1'b0;
        m_code[i] = 0;
        m_age[i]  = 0;
    endtask

    // One clock edge of behaviour: release lasts a cycle, a grant ends on its
    // own done bit or after being held for TIMEOUT cycles, idle accepts valid.
    task automatic model_step(input int i);
        if (m_rel[i]) begin
            m_rel[i]  = 1'b0;
            m_terr[i] = 1'b0;
        end else if (m_on[i]) begin
            m_age[i]++;
            if (done[m_code[i]]) begin
                m_on[i]  = 1'b0;
                m_rel[i] = 1'b1;
            end else if (m_tout[i] != 0 && m_age[i] == m_tout[i]) begin
                m_on[i]   = 1'b0;
                m_rel[i]  = 1'b1;
                m_terr[i] = 1'b1;
            end
        end else if (in_valid) begin
            m_on[i]   = 1'b1;
            m_code[i] = int'(in_code);
            m_age[i]  = 0;
        end
    endtask

    task automatic check_unit(input string nm, input int i, input logic [3:0] g,
                              input logic gv, input logic rdy, input logic bsy, input logic te);
        logic [31:0] exp_g;
        exp_g = m_on[i] ? (32'd1 << m_code[i]) : 32'd0;
        check({nm, ".gnt"},         32'(g),   exp_g);
        check({nm, ".gnt_valid"},   32'(gv),  32'(m_on[i]));
        check({nm, ".in_ready"},    32'(rdy), 32'(!m_on[i] && !m_rel[i]));
        check({nm, ".busy"},        32'(bsy), 32'(m_on[i] || m_rel[i]));
        check({nm, ".timeout_err"}, 32'(te),  32'(m_terr[i]));
    endtask

    task automatic check_all();
        check_unit("a", 0, gnt_a, gv_a, rdy_a, busy_a, te_a);
        check_unit("b", 1, gnt_b, gv_b, rdy_b, busy_b, te_b);
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) model_reset(i);
            else        model_step(i);
        end
        #1;
        check_all();
    endtask

    initial begin
        model_reset(0);
        model_reset(1);

        // Reset then idle
        repeat (2) cycle();
        #3 rst_n = 1'b1;
        #1;
        check("reset.gnt",      32'(gnt_a), 32'h0);
        check("reset.in_ready", 32'(rdy_a), 32'h1);
        check("reset.busy",     32'(busy_a), 32'h0);
        check("reset.terr",     32'(te_a),  32'h0);
        check_all();
        cycle();

        // Decode all codes, 3-cycle period
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_code  = 2'(c);
            cycle();
            in_valid = 1'b0;
            check("dec.gnt_on", 32'(gnt_a), 32'd1 << c);
            done = 4'(1 << c);
            cycle();
            done = '0;
            check("dec.gnt_off", 32'(gnt_a), 32'h0);
            check("dec.release_not_ready", 32'(rdy_a), 32'h0);
            cycle();
            check("dec.idle_ready", 32'(rdy_a), 32'h1);
        end

        // Wrong completion: foreign done ignored, own done after 6 cycles
        in_valid = 1'b1;
        in_code  = 2'd2;
        cycle();
        in_valid = 1'b0;
        n = 0;
        for (int t = 0; t < 12; t++) begin
            if (gnt_a != 4'b0100) break;
            n++;
            done = (t == 0) ? 4'b0001 : (t == 5) ? 4'b0100 : 4'b0000;
            cycle();
        end
        done = '0;
        check("wrong.hold_cycles", 32'(n), 32'd6);
        check("wrong.no_terr", 32'(te_a), 32'h0);
        repeat (3) cycle();

        // Timeout on the TIMEOUT=4 instance
        in_valid = 1'b1;
        in_code  = 2'd1;
        cycle();
        in_valid = 1'b0;
        n = 0;
        for (int t = 0; t < 20; t++) begin
            if (gnt_b != 4'b0010) break;
            n++;
            cycle();
        end
        check("tout.hold_cycles", 32'(n), 32'd4);
        check("tout.terr_pulse", 32'(te_b), 32'h1);
        cycle();
        check("tout.terr_clear", 32'(te_b), 32'h0);
        done = 4'b0010;
        cycle();
        done = '0;
        repeat (2) cycle();

        // Tie: done in the 4th grant cycle beats the timeout
        in_valid = 1'b1;
        in_code  = 2'd1;
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        check("tie.still_granted", 32'(gnt_b), 32'h2);
        done = 4'b0010;
        cycle();
        done = '0;
        check("tie.gnt_off", 32'(gnt_b), 32'h0);
        check("tie.no_terr", 32'(te_b), 32'h0);
        repeat (2) cycle();

        // Backpressure: held valid during a grant is accepted only once idle
        in_valid = 1'b1;
        in_code  = 2'd1;
        cycle();
        in_code = 2'd3;
        repeat (2) begin
            check("bp.hold", 32'(gnt_a), 32'h2);
            cycle();
        end
        check("bp.hold", 32'(gnt_a), 32'h2);
        done = 4'b0010;
        cycle();
        done = '0;
        check("bp.release_gnt", 32'(gnt_a), 32'h0);
        check("bp.release_rdy", 32'(rdy_a), 32'h0);
        cycle();
        check("bp.idle_rdy", 32'(rdy_a), 32'h1);
        cycle();
        check("bp.accept3", 32'(gnt_a), 32'h8);
        in_valid = 1'b0;
        done = 4'b1000;
        cycle();
        done = '0;
        repeat (2) cycle();

        // Async reset mid-grant
        in_valid = 1'b1;
        in_code  = 2'd1;
        cycle();
        in_valid = 1'b0;
        check("arst.pre", 32'(gnt_a), 32'h2);
        #3 rst_n = 1'b0;
        #1;
        check("arst.gnt_a", 32'(gnt_a), 32'h0);
        check("arst.gv_a",  32'(gv_a),  32'h0);
        check("arst.gnt_b", 32'(gnt_b), 32'h0);
        model_reset(0);
        model_reset(1);
        check_all();
        cycle();
        #3 rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            cycle();
            check("arst.no_terr", 32'(te_a | te_b), 32'h0);
        end

        // Randomised traffic against the model
        for (int t = 0; t < 400; t++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_code  = 2'($urandom_range(0, 3));
            done     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            cycle();
        end
        in_valid = 1'b0;
        done = '0;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grant_decoder.md
# grant_decoder

Sequential 2-to-4 decoder for the arbitration path. It accepts an encoded index plus valid from the priority encoder and drives a registered one-hot grant to the selected unit. The grant is held until that unit signals completion, or until a timeout expires. It then releases and accepts the next code.

## Interface
- `N_SEL`, default 2: width of the input code. Grant width is `2**N_SEL`.
- `TIMEOUT`, default 15: maximum cycles a grant is held without completion. 0 disables the timeout.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_code`  in  N_SEL  encoded index of the unit to grant.
- `in_valid`  in  1  `in_code` is valid.
- `in_ready`  out  1  block can accept a code this cycle.
- `gnt`  out  2**N_SEL  one-hot grant, registered.
- `gnt_valid`  out  1  a grant is currently asserted; equals the OR of `gnt`.
- `done`  in  2**N_SEL  per-unit completion. Only the bit of the granted unit is honoured.
- `timeout_err`  out  1  one-cycle pulse when a grant is dropped by timeout.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1, `gnt`=0.
  - GRANT: `gnt` = one-hot of the latched code.
  - RELEASE: one cycle, `gnt`=0, `in_ready`=0.
- IDLE to GRANT: when `in_valid && in_ready` at an edge.
  - Latch `in_code`.
  - Load the timeout counter with 0.
  - `gnt[in_code]` goes to 1 after that edge.
- GRANT, `done[code]`=1 at an edge: go to RELEASE; `gnt` clears after that edge.
- GRANT, `done` bits of non-granted units: ignored, with no state change.
- GRANT, counter reaches `TIMEOUT`-1 without `done[code]`: go to RELEASE and pulse `timeout_err` for the RELEASE cycle.
- GRANT, `done[code]` and timeout expire at the same edge: `done` wins and `timeout_err` stays 0.
- RELEASE to IDLE: unconditional.
- `in_valid` while `in_ready`=0: ignored, not queued. The source holds `in_valid` until it sees `in_ready`.
- Timeout counter:
  - Width is `$clog2(TIMEOUT+1)`, minimum 1.
  - Increments each cycle in GRANT and saturates.
  - When `TIMEOUT`=0 it is never compared, and a grant is held indefinitely.
- Every code value 0 to `2**N_SEL`-1 is legal; no invalid-code case exists.
- Reset values:
  - state = IDLE
  - `gnt` = 0, `gnt_valid` = 0
  - `timeout_err` = 0, `busy` = 0
  - `in_ready` = 1 (combinational from state)
  - counter = 0, latched code = 0
- Reset asserted mid-grant: `gnt` drops immediately (asynchronous) and no `timeout_err` is issued.

## Timing
- Accept at edge k gives `gnt` visible from edge k to edge k+1; latency is 1 cycle.
- Earliest `done` is sampled at edge k+1, giving RELEASE from k+1 to k+2, IDLE from k+2, and the next accept at edge k+3.
- Minimum grant-to-grant period is 3 cycles. There is always at least one all-zero `gnt` cycle between grants, so two units are never granted in consecutive cycles.
- Timeout with `TIMEOUT`=T: `gnt` is high for exactly T cycles, then `timeout_err` is high for 1 cycle.
- `in_ready` and `busy` are combinational from the state register only, with no input-to-output combinational path. `gnt` and `timeout_err` come directly from flops.

## Structure
- Shared package `arb_pkg`:
  - State enum `gd_state_t` (IDLE, GRANT, RELEASE).
  - Default `N_SEL` and `TIMEOUT` constants, shared with the priority encoder.
- One sub-module, `onehot_dec`: combinational `N_SEL`-to-`2**N_SEL` decoder, reused to index `done`.
- Everything else is in the single FSM module.

## Test plan
- Reset then idle: after `rst_n` deasserts, `gnt`=0000, `in_ready`=1, `busy`=0, `timeout_err`=0.
- Decode all codes: `in_code`=0,1,2,3 in turn, each completed by the matching `done` one cycle later. Expect `gnt`=0001, 0010, 0100, 1000, each high for exactly 1 cycle, with a 3-cycle period.
- Wrong completion: grant code 2, pulse `done`=0001, then assert `done`=0100 five cycles later. Expect `gnt`=0100 for 6 cycles, then 0000, with no `timeout_err`.
- Timeout and tie:
  - With `TIMEOUT`=4 and `done` held 0, expect `gnt` high for 4 cycles, then one `timeout_err` pulse.
  - Rerun with `done` asserted in the 4th cycle; expect no `timeout_err`.
- Backpressure: hold `in_valid`=1 with `in_code`=3 during GRANT of code 1. Expect no change to `gnt`; code 3 is accepted on the first IDLE cycle after RELEASE.
- Async reset mid-grant: pull `rst_n` low between clock edges while `gnt`=0010. Expect `gnt`=0000 immediately, with no `timeout_err` after reset releases.
